// File: rtl/mul_div_sequencer_pkg.sv
// Shared encodings for the MULT/MULTU/DIV/DIVU sequencer and its ALU.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_ZDIV = 2'd3
    } state_e;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    localparam int MULDIV_ITERS = 32;

    // Two's-complement negation of a 32-bit word.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/mul_div_sequencer_alu.sv
// 32-bit ALU used by the sequencer as its iteration adder/subtractor.
module ALU32Bit
    import muldiv_pkg::*;
(
    input  logic [3:0]  ALUControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ALUResult,
    output logic        Zero
);

    // Combinational result select by control code.
    always_comb begin
        ALUResult = 32'd0;
        case (ALUControl)
            ALU_AND: ALUResult = A & B;
            ALU_OR:  ALUResult = A | B;
            ALU_ADD: ALUResult = A + B;
            ALU_SUB: ALUResult = A - B;
            ALU_SLT: ALUResult = {31'd0, $signed(A) < $signed(B)};
            default: ALUResult = 32'd0;
        endcase
    end

    assign Zero = (ALUResult == 32'd0);

endmodule

// File: rtl/mul_div_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Build option: MULDIV_DIV_EN enables the divide datapath and the
// divide-by-zero path; without it DIV/DIVU complete one cycle after
// Start with HI/LO untouched.
//
// state  | meaning
// S_IDLE | waiting for Start; operands latched and made unsigned here
// S_ITER | 32 shift-add (multiply) or restoring-subtract (divide) steps
// S_FIX  | phase 0: sign correction; phase 1: write HI/LO, pulse Done
// S_ZDIV | divide by zero (or divide disabled): complete next edge
module mul_div_sequencer
    import muldiv_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    output logic        Busy,
    output logic        Done,
    output logic        DivByZero,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] opb_q, opb_d;       // multiplicand or divisor magnitude
    logic [31:0] acc_hi_q, acc_hi_d; // product high word or remainder
    logic [31:0] acc_lo_q, acc_lo_d; // multiplier/product low or quotient
    logic        neg_q, neg_d;       // product or quotient must be negated
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        is_signed_op, is_div_op;
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;

    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a, alu_res;
    logic        alu_zero_unused;

    logic        mul_carry;
    logic [31:0] mul_hi_nxt, mul_lo_nxt;
    logic [63:0] prod_neg;

    assign is_signed_op = (Op == OP_MULT) || (Op == OP_DIV);
    assign is_div_op    = (Op == OP_DIV)  || (Op == OP_DIVU);
    assign sign_a       = is_signed_op & A[31];
    assign sign_b       = is_signed_op & B[31];
    // abs(0x80000000) stays 0x80000000, which is the right unsigned magnitude.
    assign mag_a        = sign_a ? neg32(A) : A;
    assign mag_b        = sign_b ? neg32(B) : B;

`ifdef MULDIV_DIV_EN
    logic        is_div_q, is_div_d;
    logic        rem_neg_q, rem_neg_d;
    logic        dbz_q, dbz_d;
    logic [31:0] rem_shift;
    logic        div_borrow, div_ok;
    logic [31:0] div_hi_nxt, div_lo_nxt;

    assign alu_ctrl   = is_div_q ? ALU_SUB : ALU_ADD;
    assign alu_a      = is_div_q ? rem_shift : acc_hi_q;
    // Bit shifted out of the remainder is an implicit 33rd bit: when set the
    // subtraction always succeeds and the 32-bit ALU result is still exact.
    assign rem_shift  = {acc_hi_q[30:0], acc_lo_q[31]};
    assign div_borrow = (alu_res > rem_shift);
    assign div_ok     = acc_hi_q[31] | ~div_borrow;
    assign div_hi_nxt = div_ok ? alu_res : rem_shift;
    assign div_lo_nxt = {acc_lo_q[30:0], div_ok};
    assign DivByZero  = dbz_q;
`else
    assign alu_ctrl   = ALU_ADD;
    assign alu_a      = acc_hi_q;
    assign DivByZero  = 1'b0;
`endif

    ALU32Bit u_alu (
        .ALUControl (alu_ctrl),
        .A          (alu_a),
        .B          (opb_q),
        .ALUResult  (alu_res),
        .Zero       (alu_zero_unused)
    );

    // Shift-add step: optional add, then shift {carry, high, low} right by one.
    assign mul_carry  = (alu_res < acc_hi_q);
    assign mul_hi_nxt = acc_lo_q[0] ? {mul_carry, alu_res[31:1]} : {1'b0, acc_hi_q[31:1]};
    assign mul_lo_nxt = {(acc_lo_q[0] ? alu_res[0] : acc_hi_q[0]), acc_lo_q[31:1]};
    assign prod_neg   = ~{acc_hi_q, acc_lo_q} + 64'd1;

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opb_d    = opb_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        rem_neg_d = rem_neg_q;
        dbz_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start && !Flush) begin
                    cnt_d = 5'd0;
                    neg_d = sign_a ^ sign_b;
                    if (is_div_op) begin
`ifdef MULDIV_DIV_EN
                        is_div_d  = 1'b1;
                        rem_neg_d = sign_a;
                        if (B == 32'd0) begin
                            acc_lo_d = A;
                            state_d  = S_ZDIV;
                        end else begin
                            acc_hi_d = 32'd0;
                            acc_lo_d = mag_a;
                            opb_d    = mag_b;
                            state_d  = S_ITER;
                        end
`else
                        state_d = S_ZDIV;
`endif
                    end else begin
`ifdef MULDIV_DIV_EN
                        is_div_d  = 1'b0;
                        rem_neg_d = 1'b0;
`endif
                        acc_hi_d = 32'd0;
                        acc_lo_d = mag_b;
                        opb_d    = mag_a;
                        state_d  = S_ITER;
                    end
                end
            end
            S_ITER: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_hi_d = mul_hi_nxt;
                    acc_lo_d = mul_lo_nxt;
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        acc_hi_d = div_hi_nxt;
                        acc_lo_d = div_lo_nxt;
                    end
`endif
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(MULDIV_ITERS - 1)) begin
                        cnt_d   = 5'd0;
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 5'd0) begin
                    cnt_d = 5'd1;
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        if (neg_q)     acc_lo_d = neg32(acc_lo_q);
                        if (rem_neg_q) acc_hi_d = neg32(acc_hi_q);
                    end else
`endif
                    if (neg_q) {acc_hi_d, acc_lo_d} = prod_neg;
                end else begin
                    hi_d    = acc_hi_q;
                    lo_d    = acc_lo_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ZDIV: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
`ifdef MULDIV_DIV_EN
                    hi_d  = acc_lo_q;
                    lo_d  = 32'hFFFF_FFFF;
                    dbz_d = 1'b1;
`endif
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            opb_q    <= 32'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            neg_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opb_q    <= opb_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            rem_neg_q <= rem_neg_d;
            dbz_q     <= dbz_d;
`endif
        end
    end

    assign Busy = (state_q != S_IDLE);
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule
